// File: rtl/inst_constraint_pkg.sv
// rtl/inst_constraint_pkg.sv - opcode/funct constants, NOP word and class enum for the QED subset
package inst_constraint_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_SR      = 3'b101;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_R_ALU   = 3'd1,
    CLS_I_ALU   = 3'd2,
    CLS_LUI     = 3'd3,
    CLS_LW      = 3'd4,
    CLS_SW      = 3'd5,
    CLS_NOP     = 3'd6
  } cls_e;

endpackage

// File: rtl/inst_constraint_dec.sv
// rtl/inst_constraint_dec.sv - combinational subset decoder; RV32M acceptance under INST_CONSTRAINT_MULDIV_EN
module inst_constraint_dec
  import inst_constraint_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        legal,
  output logic        dup,
  output cls_e        cls
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;
  logic       muldiv_ok;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

`ifdef INST_CONSTRAINT_MULDIV_EN
  assign muldiv_ok = (funct7 == F7_MULDIV);
`else
  assign muldiv_ok = 1'b0;
`endif

  logic fmt_ok;
  logic same_half;
  logic hi_half;
  logic need_rd;
  logic base_legal;
  cls_e fmt_cls;

  // Per-format encoding check, register-half agreement and the half the instruction lives in
  always_comb begin
    fmt_ok    = 1'b0;
    same_half = 1'b0;
    hi_half   = rd[4];
    need_rd   = 1'b1;
    fmt_cls   = CLS_ILLEGAL;
    case (opcode)
      OPC_OP: begin
        fmt_ok    = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR))) ||
                    muldiv_ok;
        same_half = (rd[4] == rs1[4]) && (rs1[4] == rs2[4]);
        fmt_cls   = CLS_R_ALU;
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL)     fmt_ok = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) fmt_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                      fmt_ok = 1'b1;
        same_half = (rd[4] == rs1[4]);
        fmt_cls   = CLS_I_ALU;
      end
      OPC_LUI: begin
        fmt_ok    = 1'b1;
        same_half = 1'b1;
        fmt_cls   = CLS_LUI;
      end
      OPC_LOAD: begin
        fmt_ok    = (funct3 == F3_WORD);
        same_half = (rd[4] == rs1[4]);
        fmt_cls   = CLS_LW;
      end
      OPC_STORE: begin
        fmt_ok    = (funct3 == F3_WORD);
        same_half = (rs1[4] == rs2[4]);
        hi_half   = rs1[4];
        need_rd   = 1'b0;
        fmt_cls   = CLS_SW;
      end
      default: ;
    endcase
    // x0 and its duplicate x16 are never valid destinations
    base_legal = fmt_ok && same_half && (!need_rd || (rd[3:0] != 4'd0));
  end

  // NOP is ADDI x0,x0,0 and would otherwise trip the x0 rule, so it is matched first
  always_comb begin
    if (instruction == NOP_INST) begin
      legal = 1'b1;
      dup   = 1'b0;
      cls   = CLS_NOP;
    end else begin
      legal = base_legal;
      dup   = base_legal && hi_half;
      cls   = base_legal ? fmt_cls : CLS_ILLEGAL;
    end
  end

endmodule

// File: rtl/inst_constraint.sv
// rtl/inst_constraint.sv - QED instruction constraint checker top; optional RV32M via INST_CONSTRAINT_MULDIV_EN
module inst_constraint
  import inst_constraint_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_vld,
  input  logic [31:0]      instruction,
  output logic             legal,
  output logic             dup,
  output logic [2:0]       cls,
  output logic             viol,
  output logic [31:0]      viol_inst,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  cls_e dec_cls;

  inst_constraint_dec u_dec (
    .instruction (instruction),
    .legal       (legal),
    .dup         (dup),
    .cls         (dec_cls)
  );

  assign cls = dec_cls;

  // Sticky violation capture (first offender only) and saturating per-half counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol      <= 1'b0;
      viol_inst <= 32'd0;
      orig_cnt  <= '0;
      dup_cnt   <= '0;
    end else if (inst_vld) begin
      if (!legal) begin
        viol <= 1'b1;
        if (!viol) viol_inst <= instruction;
      end else if (dec_cls != CLS_NOP) begin
        if (dup) begin
          if (dup_cnt != CNT_MAX) dup_cnt <= dup_cnt + 1'b1;
        end else begin
          if (orig_cnt != CNT_MAX) orig_cnt <= orig_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_constraint.sv
// tb/tb_inst_constraint.sv - directed plus randomized checks of inst_constraint against a rule-level model
module tb_inst_constraint;

  localparam int CNT_W   = 2;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inst_vld = 1'b0;
  logic [31:0]      instruction = 32'd0;
  logic             legal;
  logic             dup;
  logic [2:0]       cls;
  logic             viol;
  logic [31:0]      viol_inst;
  logic [CNT_W-1:0] orig_cnt;
  logic [CNT_W-1:0] dup_cnt;

  inst_constraint #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_vld    (inst_vld),
    .instruction (instruction),
    .legal       (legal),
    .dup         (dup),
    .cls         (cls),
    .viol        (viol),
    .viol_inst   (viol_inst),
    .orig_cnt    (orig_cnt),
    .dup_cnt     (dup_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // expected registered state
  bit          m_viol = 1'b0;
  logic [31:0] m_vinst = 32'd0;
  int          m_orig = 0;
  int          m_dup  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Rule-level model: list which register fields the format reads/writes, then apply the rules
  task automatic ref_decode(input logic [31:0] w, output bit l, output bit d, output int c);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit   ok;
    bit   use_rd, use_rs1, use_rs2;
    int   fmt;
    int   halves [$];
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ok = 0; use_rd = 0; use_rs1 = 0; use_rs2 = 0; fmt = 0;
    if (op == 7'h33) begin
      fmt = 1; use_rd = 1; use_rs1 = 1; use_rs2 = 1;
      ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
`ifdef INST_CONSTRAINT_MULDIV_EN
      if (f7 == 7'h01) ok = 1;
`endif
    end else if (op == 7'h13) begin
      fmt = 2; use_rd = 1; use_rs1 = 1;
      ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
    end else if (op == 7'h37) begin
      fmt = 3; use_rd = 1; ok = 1;
    end else if (op == 7'h03) begin
      fmt = 4; use_rd = 1; use_rs1 = 1; ok = (f3 == 2);
    end else if (op == 7'h23) begin
      fmt = 5; use_rs1 = 1; use_rs2 = 1; ok = (f3 == 2);
    end
    if (use_rd)  halves.push_back(int'(w[11]));
    if (use_rs1) halves.push_back(int'(w[19]));
    if (use_rs2) halves.push_back(int'(w[24]));
    foreach (halves[i]) if (halves[i] != halves[0]) ok = 0;
    if (use_rd && (w[10:7] == 4'd0)) ok = 0;
    if (w == 32'h13) begin
      l = 1; d = 0; c = 6;
    end else begin
      l = ok;
      d = ok && (halves.size() > 0) && (halves[0] == 1);
      c = ok ? fmt : 0;
    end
  endtask

  // One clock: drive, check decode mid-cycle, advance model, check registers after the edge
  task automatic step(input bit v, input logic [31:0] w, input bit r);
    bit el, ed;
    int ec;
    @(negedge clk);
    inst_vld = v; instruction = w; rst_n = r;
    #1;
    ref_decode(w, el, ed, ec);
    check("legal", legal, el);
    check("dup", dup, ed);
    check("cls", cls, ec);
    @(posedge clk);
    if (!r) begin
      m_viol = 0; m_vinst = 0; m_orig = 0; m_dup = 0;
    end else if (v) begin
      if (!el) begin
        if (!m_viol) m_vinst = w;
        m_viol = 1;
      end else if (ec != 6) begin
        if (ed) m_dup  = (m_dup  < CNT_TOP) ? m_dup + 1  : CNT_TOP;
        else    m_orig = (m_orig < CNT_TOP) ? m_orig + 1 : CNT_TOP;
      end
    end
    #1;
    check("viol", viol, m_viol);
    check("viol_inst", viol_inst, m_vinst);
    check("orig_cnt", orig_cnt, m_orig);
    check("dup_cnt", dup_cnt, m_dup);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [5];
    logic [6:0]  f7s [3];
    bit          hi;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h03; ops[4] = 7'h23;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;
    if ($urandom_range(0, 11) == 0) return 32'h13;
    w = $urandom;
    case ($urandom_range(0, 5))
      0, 1, 2, 3, 4: w[6:0] = ops[$urandom_range(0, 4)];
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
    if ($urandom_range(0, 1) == 1) w[14:12] = 3'd2;
    hi = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 4) != 0) begin
      w[11] = hi; w[19] = hi; w[24] = hi;
    end
    return w;
  endfunction

  initial begin
    // reset, with a valid illegal word present: reset must win
    step(1, 32'hFFFF_FFFF, 0);
    check("reset_viol", viol, 0);
    check("reset_orig", orig_cnt, 0);

    // ADD x1,x2,x3
    step(1, 32'h003100B3, 1);
    check("add_legal", legal, 1);
    check("add_dup", dup, 0);
    check("add_cls", cls, 1);
    check("add_orig", orig_cnt, 1);

    // ADD x17,x18,x19
    step(1, 32'h013908B3, 1);
    check("add_hi_dup", dup, 1);
    check("add_hi_dupcnt", dup_cnt, 1);

    // NOP leaves counters alone
    step(1, 32'h00000013, 1);
    check("nop_cls", cls, 6);
    check("nop_orig", orig_cnt, 1);
    check("nop_dupcnt", dup_cnt, 1);

    // MUL x1,x2,x3
    step(1, 32'h023100B3, 1);
`ifdef INST_CONSTRAINT_MULDIV_EN
    check("mul_legal", legal, 1);
`else
    check("mul_legal", legal, 0);
`endif

    // mixed-half ADD is the first violation; later ones must not overwrite it
    step(1, 32'h0, 0);
    step(1, 32'h013100B3, 1);
    check("mix_legal", legal, 0);
    check("mix_viol", viol, 1);
    check("mix_vinst", viol_inst, 32'h013100B3);
    step(1, 32'h401080B3, 1);
    step(1, 32'h00108013, 1);
    check("addi_x0_legal", legal, 0);
    check("vinst_kept", viol_inst, 32'h013100B3);

    // hold while inst_vld is low
    step(0, 32'h003100B3, 1);
    check("hold_orig", orig_cnt, 1);

    // saturation, then reset mid-stream
    step(1, 32'h0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h003100B3, 1);
    check("sat_orig", orig_cnt, 3);
    step(1, 32'h003100B3, 0);
    check("midrst_orig", orig_cnt, 0);
    check("midrst_vinst", viol_inst, 0);

    // randomized traffic with occasional resets and idle cycles
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 5) != 0, rand_inst(), $urandom_range(0, 24) != 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
